fifo_rd_stream: RTL and testbench

//  Read-side consumer for the async FIFO, in the rd_clk domain.
//  - Issues rd_en toward the FIFO read port.
//  - Absorbs the 1-cycle read latency (rd_data qualified by data_out_vld).
//  - Presents a valid/ready stream to downstream CNN datapath logic.
//  - 2-entry output buffer sustains 1 beat/cycle; out_last marks every frame_len-th beat (one feature-map row).

---
 rtl/fifo_rd_stream.sv | 77 +++++++
 tb/tb_fifo_rd_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for an async FIFO: issues rd_en, absorbs the 1-cycle read latency,
// and presents a 2-entry buffered valid/ready stream with per-frame out_last.
module fifo_rd_stream #(
  parameter int width     = 8,
  parameter int frame_len = 16
) (
  input  logic             rd_clk,
  input  logic             rest,
  input  logic             en,
  input  logic             empty,
  output logic             rd_en,
  input  logic [width-1:0] rd_data,
  input  logic             data_out_vld,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
  output logic             err_unexp
);

  localparam int bw = (frame_len > 1) ? $clog2(frame_len) : 1;
  localparam logic [bw-1:0] last_beat = bw'(frame_len - 1);

  logic [width-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             inflight;
  logic [1:0]       cnt;
  logic [bw-1:0]    beat_cnt;
  logic             pop;
  logic             push;
  logic [2:0]       occ_after;

  assign pop  = out_valid & out_ready;
  assign push = data_out_vld & inflight;

  // Occupancy once this cycle's pop leaves, counting the word already in flight.
  assign occ_after = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en     = ~rest & en & ~empty & (occ_after < 3'd2);

  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign out_last  = out_valid & (beat_cnt == last_beat);

  always_ff @(posedge rd_clk or posedge rest) begin
    if (rest) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      inflight  <= 1'b0;
      cnt       <= 2'd0;
      beat_cnt  <= '0;
      err_unexp <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (push) begin
        mem[wr_ptr] <= rd_data;
        wr_ptr      <= ~wr_ptr;
      end
      // A stray valid with nothing requested is dropped, never buffered.
      if (data_out_vld && !inflight) begin
        err_unexp <= 1'b1;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= (beat_cnt == last_beat) ? '0 : beat_cnt + bw'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream with a queue-based FIFO and stream scoreboard.
module tb_fifo_rd_stream;
  localparam int FL = 16;

  logic       rd_clk = 1'b0;
  logic       rest;
  logic       en;
  logic       empty;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       data_out_vld;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       err_unexp;

  fifo_rd_stream #(.width(8), .frame_len(FL)) dut (
    .rd_clk(rd_clk), .rest(rest), .en(en), .empty(empty), .rd_en(rd_en),
    .rd_data(rd_data), .data_out_vld(data_out_vld), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_unexp(err_unexp)
  );

  always #5 rd_clk = ~rd_clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sb_q[$];
  bit         pend_vld;
  logic [7:0] pend_data;
  int         buffered;
  int         beats;
  int         pop_cnt;
  int         rd_cnt;
  bit         err_exp;

  logic       s_rd_en, s_out_valid, s_out_last, s_err, s_pop;
  logic [7:0] s_out_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    fifo_q.delete();
    sb_q.delete();
    pend_vld = 0;
    buffered = 0;
    beats    = 0;
    err_exp  = 0;
  endtask

  task automatic tick(input bit en_i, input bit rdy_i, input bit gap_i, input bit force_i);
    @(negedge rd_clk);
    en           = en_i;
    out_ready    = rdy_i;
    empty        = gap_i || (fifo_q.size() == 0);
    data_out_vld = pend_vld | force_i;
    rd_data      = pend_vld ? pend_data : 8'($urandom);
    #1;
    s_rd_en     = rd_en;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_out_last  = out_last;
    s_err       = err_unexp;
    s_pop       = out_valid & out_ready;

    chk("valid_vs_occ", out_valid, buffered != 0);
    chk("err_flag", err_unexp, err_exp);
    if (empty) chk("rd_en_while_empty", rd_en, 0);
    if (!en_i) chk("rd_en_while_dis", rd_en, 0);
    if (out_valid && sb_q.size() > 0) chk("head_data", out_data, sb_q[0]);
    if (s_pop) begin
      chk("last_flag", out_last, (beats % FL) == FL - 1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      beats++;
      pop_cnt++;
      buffered--;
    end else if (out_valid) begin
      chk("last_flag_hold", out_last, (beats % FL) == FL - 1);
    end

    if (pend_vld) buffered++;
    else if (force_i) err_exp = 1;
    chk("occ_le2", buffered <= 2, 1);
    pend_vld = 0;
    if (rd_en && fifo_q.size() > 0) begin
      pend_data = fifo_q.pop_front();
      pend_vld  = 1;
      sb_q.push_back(pend_data);
      rd_cnt++;
    end
    @(posedge rd_clk);
  endtask

  task automatic hard_reset();
    #2;
    rest = 1'b1;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err_unexp, 0);
    data_out_vld = 1'b0;
    model_clear();
    @(posedge rd_clk);
    @(negedge rd_clk);
    rest = 1'b0;
  endtask

  initial begin
    int p0, r0, guard, produced;
    rest = 1'b1; en = 1'b0; empty = 1'b1; out_ready = 1'b0;
    data_out_vld = 1'b0; rd_data = 8'h00;
    model_clear();
    pop_cnt = 0; rd_cnt = 0;
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    rest = 1'b0;

    // Reset pulsed mid-stream.
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h30 + i));
    repeat (4) tick(1, 1, 0, 0);
    chk("pre_rst_active", s_out_valid, 1);
    hard_reset();
    repeat (3) tick(1, 1, 0, 0);
    chk("post_rst_idle", s_out_valid, 0);

    // First-word latency.
    fifo_q.push_back(8'hA5);
    p0 = pop_cnt;
    tick(1, 1, 0, 0);
    chk("lat_rd_en_N", s_rd_en, 1);
    chk("lat_valid_N", s_out_valid, 0);
    tick(1, 1, 0, 0);
    chk("lat_valid_N1", s_out_valid, 0);
    tick(1, 1, 0, 0);
    chk("lat_valid_N2", s_out_valid, 1);
    chk("lat_data", s_out_data, 8'hA5);
    tick(1, 1, 0, 0);
    chk("lat_one_beat", pop_cnt - p0, 1);

    // Full-rate streaming across frame boundaries.
    hard_reset();
    for (int i = 0; i < 40; i++) fifo_q.push_back(8'(i));
    repeat (2) tick(1, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      tick(1, 1, 0, 0);
      chk("tput_pop", s_pop, 1);
      chk("tput_data", s_out_data, i);
      chk("tput_last", s_out_last, (i == 15) || (i == 31));
    end
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'hC0 + i));
    repeat (2) tick(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 0, 0);
      chk("wrap_last", s_out_last, i == 7);
    end

    // Backpressure.
    hard_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h50 + i));
    r0 = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 0, 0);
      if (i >= 2) chk("bp_hold", s_out_data, 8'h50);
    end
    chk("bp_rd_pulses", rd_cnt - r0, 2);
    p0 = pop_cnt; guard = 0;
    while ((sb_q.size() > 0 || fifo_q.size() > 0) && guard < 100) begin
      tick(1, 1, 0, 0);
      guard++;
    end
    repeat (2) tick(1, 1, 0, 0);
    chk("bp_drained", pop_cnt - p0, 8);

    // Random ready and empty gaps.
    p0 = pop_cnt; guard = 0; produced = 0;
    while ((pop_cnt - p0) < 1000 && guard < 20000) begin
      if (produced < 1000 && $urandom_range(0, 3) != 0) begin
        fifo_q.push_back(8'($urandom));
        produced++;
      end
      tick(1, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, 0);
      guard++;
    end
    chk("rand_beats", pop_cnt - p0, 1000);

    // en=0 with a read in flight, then a stray data valid.
    hard_reset();
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'(8'h70 + i));
    p0 = pop_cnt;
    tick(1, 1, 0, 0);
    chk("en0_first_rd", s_rd_en, 1);
    repeat (4) tick(0, 1, 0, 0);
    chk("en0_delivered", pop_cnt - p0, 1);
    chk("en0_fifo_left", fifo_q.size(), 2);
    tick(0, 1, 0, 1);
    repeat (3) tick(0, 1, 0, 0);
    chk("err_set", s_err, 1);
    chk("err_dropped", s_out_valid, 0);
    repeat (3) tick(1, 1, 0, 0);
    chk("err_sticky", s_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
